// File: rtl/lvds_tx_serializer.sv
// Word-to-bit serializer feeding the LVDS output buffer: one DATA_W-bit word per DATA_W bit clocks.
// An idle word fills the line whenever upstream starves at a word boundary.
module lvds_tx_serializer #(
  parameter int                DATA_W      = 10,
  parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(10'b1101010100),
  parameter bit                LSB_FIRST   = 1'b1,
  parameter int                UFLOW_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   ser_o,
  output logic                   word_start,
  output logic                   underflow,
  output logic [UFLOW_CNT_W-1:0] uflow_cnt
);

  generate
    if (DATA_W < 2) begin : g_bad_width
      $error("lvds_tx_serializer: DATA_W must be >= 2");
    end
  endgenerate

  localparam int               CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [DATA_W-1:0]      r_sh;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_uflow;
  logic [UFLOW_CNT_W-1:0] r_ucnt;
  logic                   w_lp;
  logic                   w_last;
  logic [DATA_W-1:0]      w_sh_shift;

  assign w_last = (r_cnt == LAST);
  assign w_lp   = ((r_state == ST_IDLE) && en) || ((r_state == ST_RUN) && w_last);

  // Shift toward whichever end drives ser_o, zero-filling behind.
  assign w_sh_shift = LSB_FIRST ? {1'b0, r_sh[DATA_W-1:1]} : {r_sh[DATA_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = en ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates s_ready: nothing is accepted on a reset edge.
  always_comb begin
    s_ready    = rst_n && w_lp && en;
    word_start = (r_state == ST_RUN) && (r_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_cnt   <= LAST;
      r_uflow <= 1'b0;
      r_ucnt  <= '0;
    end else begin
      r_uflow <= 1'b0;
      if (w_lp && en) begin
        r_sh  <= s_valid ? s_data : IDLE_WORD;
        r_cnt <= '0;
        if ((r_state == ST_RUN) && !s_valid) begin
          r_uflow <= 1'b1;
          if (r_ucnt != '1) r_ucnt <= r_ucnt + UFLOW_CNT_W'(1);
        end
      end else if ((r_state == ST_RUN) && w_last) begin
        // en dropped at a word boundary: park the line low
        r_sh  <= '0;
        r_cnt <= LAST;
      end else if (r_state == ST_RUN) begin
        r_sh  <= w_sh_shift;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ser_o     = LSB_FIRST ? r_sh[0] : r_sh[DATA_W-1];
  assign underflow = r_uflow;
  assign uflow_cnt = r_ucnt;

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Directed bench: vector table for the LSB-first default build, plus a hand sequence
// for an MSB-first build with a 2-bit saturating underflow counter.
module tb_lvds_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n, en, s_valid;
  logic [9:0]  s_data;
  logic        s_ready, ser_o, word_start, underflow;
  logic [15:0] uflow_cnt;
  logic        m_ready, m_ser, m_ws, m_uf;
  logic [1:0]  m_cnt;

  always #5 clk = ~clk;

  lvds_tx_serializer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ser_o(ser_o), .word_start(word_start),
    .underflow(underflow), .uflow_cnt(uflow_cnt)
  );

  lvds_tx_serializer #(.LSB_FIRST(1'b0), .UFLOW_CNT_W(2)) dut_m (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(m_ready), .ser_o(m_ser), .word_start(m_ws),
    .underflow(m_uf), .uflow_cnt(m_cnt)
  );

  typedef struct {
    logic        rst_n, en, vld;
    logic [9:0]  data;
    logic        rdy, ser, ws, uf;
    logic [15:0] cnt;
  } vec_t;

  vec_t       vq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] wd, wi;

  function automatic void add(input logic r, input logic e, input logic v, input logic [9:0] d,
                              input logic rdy, input logic ser, input logic ws, input logic uf,
                              input logic [15:0] c);
    vec_t t;
    t.rst_n = r; t.en = e; t.vld = v; t.data = d;
    t.rdy = rdy; t.ser = ser; t.ws = ws; t.uf = uf; t.cnt = c;
    vq.push_back(t);
  endfunction

  // One whole word: accepted (or idle-filled) at a load point, then nine shift cycles.
  function automatic void add_word(input logic [9:0] w, input logic v, input logic uf,
                                   input logic [15:0] c);
    add(1'b1, 1'b1, v, wd, 1'b1, w[0], 1'b1, uf, c);
    for (int i = 1; i < 10; i++) add(1'b1, 1'b1, 1'b1, wd, 1'b0, w[i], 1'b0, 1'b0, c);
  endfunction

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk16(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    wd = 10'h3A5;
    wi = 10'b1101010100;

    // reset held with valid data and enable present
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, wd, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // start-up from IDLE, then a back-to-back word
    add_word(wd, 1'b1, 1'b0, 16'd0);
    add_word(wd, 1'b1, 1'b0, 16'd0);
    // starved load point in RUN -> idle word, one underflow
    add_word(wi, 1'b0, 1'b1, 16'd1);
    add_word(wd, 1'b1, 1'b0, 16'd1);
    // en drops while bit 4 is on the line; word still completes
    add(1'b1, 1'b1, 1'b1, wd, 1'b1, wd[0], 1'b1, 1'b0, 16'd1);
    for (int i = 1; i < 5; i++) add(1'b1, 1'b1, 1'b1, wd, 1'b0, wd[i], 1'b0, 1'b0, 16'd1);
    for (int i = 5; i < 10; i++) add(1'b1, 1'b0, 1'b1, wd, 1'b0, wd[i], 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b1, wd, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    // re-enable, then reset while bit 5 is on the line
    add(1'b1, 1'b1, 1'b1, wd, 1'b1, wd[0], 1'b1, 1'b0, 16'd1);
    for (int i = 1; i < 6; i++) add(1'b1, 1'b1, 1'b1, wd, 1'b0, wd[i], 1'b0, 1'b0, 16'd1);
    add(1'b0, 1'b1, 1'b1, wd, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    add_word(wd, 1'b1, 1'b0, 16'd0);
    // stop at the boundary, then start up with no data: idle word but no underflow
    add(1'b1, 1'b0, 1'b0, wd, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    add_word(wi, 1'b0, 1'b0, 16'd0);

    foreach (vq[k]) begin
      rst_n = vq[k].rst_n; en = vq[k].en; s_valid = vq[k].vld; s_data = vq[k].data;
      #1;
      chk1("s_ready", k, s_ready, vq[k].rdy);
      @(posedge clk); #1;
      chk1("ser_o", k, ser_o, vq[k].ser);
      chk1("word_start", k, word_start, vq[k].ws);
      chk1("underflow", k, underflow, vq[k].uf);
      chk16("uflow_cnt", k, uflow_cnt, vq[k].cnt);
    end

    // MSB-first build: serial order and 2-bit counter saturation
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = wd;
    @(posedge clk); #1;
    chk16("m_cnt_reset", 0, 16'(m_cnt), 16'd0);
    chk1("m_ser_reset", 0, m_ser, 1'b0);
    rst_n = 1'b1; en = 1'b1; s_valid = 1'b1;
    #1;
    chk1("m_ready_load", 0, m_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = 10'h000;
      chk1("m_ser_msb", i, m_ser, wd[9-i]);
      chk1("m_word_start", i, m_ws, (i == 0));
    end
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      chk1("m_ser_idle", k, m_ser, wi[9 - (k % 10)]);
      chk1("m_underflow", k, m_uf, (k % 10) == 0);
      if (k == 20) chk16("m_cnt_3", k, 16'(m_cnt), 16'd3);
      if (k == 30) chk16("m_cnt_sat", k, 16'(m_cnt), 16'd3);
    end
    chk16("m_cnt_final", 0, 16'(m_cnt), 16'd3);
    chk16("uflow_cnt_5", 0, uflow_cnt, 16'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
